// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address predictor fed by the fetch pre-aligner's jal/jr flags.
// Define RAS_STATS_EN to add saturating push/overflow/underflow counters.
module return_address_stack #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DEPTH = 8,
  parameter int PTR_WIDTH = 3
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Stall,
  input  logic                     i_Flush,
  input  logic                     i_jal_inst,
  input  logic                     i_jr_inst,
  input  logic [ADDRESS_WIDTH-1:0] i_branch_address,
  output logic [ADDRESS_WIDTH-1:0] o_ras_target,
  output logic                     o_ras_valid,
  output logic                     o_empty,
`ifdef RAS_STATS_EN
  output logic [15:0]              o_push_count,
  output logic [15:0]              o_overflow_count,
  output logic [15:0]              o_underflow_count,
`endif
  output logic                     o_full
);
  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
  logic [ADDRESS_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] tos, tos_inc, tos_dec;
  logic [PTR_WIDTH:0] count;
  logic [ADDRESS_WIDTH-1:0] ret_addr;
  logic push, pop;
  assign tos_inc  = tos + PTR_WIDTH'(1);
  assign tos_dec  = tos - PTR_WIDTH'(1);
  assign ret_addr = i_branch_address + ADDRESS_WIDTH'(1);
  assign push     = i_jal_inst && !i_Flush;
  assign pop      = i_jr_inst && !i_Flush;
  assign o_empty  = count == '0;
  assign o_full   = count == FULL_CNT;
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      tos <= '0;
      count <= '0;
      o_ras_target <= '0;
      o_ras_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!i_Stall) begin
      if (i_Flush) begin
        count <= '0;
        o_ras_valid <= 1'b0;
        o_ras_target <= '0;
      end else if (push && pop) begin
        // Pop sees the pre-edge top, then the new return address replaces it in place.
        o_ras_valid <= !o_empty;
        o_ras_target <= o_empty ? '0 : mem[tos];
        mem[tos] <= ret_addr;
        count <= o_empty ? (PTR_WIDTH+1)'(1) : count;
      end else if (push) begin
        tos <= tos_inc;
        mem[tos_inc] <= ret_addr;
        count <= o_full ? count : count + (PTR_WIDTH+1)'(1);
        o_ras_valid <= 1'b0;
      end else if (pop) begin
        o_ras_valid <= !o_empty;
        o_ras_target <= o_empty ? '0 : mem[tos];
        tos <= o_empty ? tos : tos_dec;
        count <= o_empty ? count : count - (PTR_WIDTH+1)'(1);
      end else begin
        o_ras_valid <= 1'b0;
      end
    end
  end
`ifdef RAS_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_push_count <= '0;
      o_overflow_count <= '0;
      o_underflow_count <= '0;
    end else if (!i_Stall) begin
      if (push) o_push_count <= sat_inc(o_push_count);
      if (push && !pop && o_full) o_overflow_count <= sat_inc(o_overflow_count);
      if (pop && o_empty) o_underflow_count <= sat_inc(o_underflow_count);
    end
  end
`endif
endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Return-address stack (RAS) directly downstream of the fetch-side pre-aligner.
- Consumes the registered jal/jr indications and the branch instruction address.
- Pushes the return address on jal and pops a predicted target on jr.
- Fetch uses the popped target instead of the junk target the pre-aligner supplies for jr.

Parameters:
- ADDRESS_WIDTH, 22, width of instruction word addresses.
- DEPTH, 8, number of stack entries; power of two, >= 2.
- PTR_WIDTH, 3, log2(DEPTH); width of top-of-stack pointer.

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Reset_n  input  1  asynchronous active-low reset.
- i_Stall  input  1  freeze; no state change, outputs hold.
- i_Flush  input  1  pipeline redirect; empties the stack.
- i_jal_inst  input  1  pre-aligner: jal detected (push request).
- i_jr_inst  input  1  pre-aligner: jr detected (pop request).
- i_branch_address  input  ADDRESS_WIDTH  word address of the jal/jr instruction.
- o_ras_target  output  ADDRESS_WIDTH  predicted jr return address.
- o_ras_valid  output  1  o_ras_target is a real prediction (one-cycle pulse).
- o_empty  output  1  count == 0.
- o_full  output  1  count == DEPTH.

Behaviour:
- Reset (async, i_Reset_n low):
  - tos = 0, count = 0, all entries = 0.
  - o_ras_target = 0, o_ras_valid = 0, o_empty = 1, o_full = 0.
- Storage: circular array mem[0..DEPTH-1]; tos points at the current top entry; count saturates at DEPTH.
- Return address = i_branch_address + 1, truncated modulo 2^ADDRESS_WIDTH.
- Priority per rising edge: i_Stall > i_Flush > push/pop.
- i_Stall = 1:
  - Nothing changes, including o_ras_valid and o_ras_target; both hold.
  - Requests presented during stall are ignored; the upstream stage holds them.
- i_Flush = 1 (not stalled):
  - count <= 0, tos unchanged, o_ras_valid <= 0, o_ras_target <= 0.
  - Entries are not cleared.
  - Any push/pop that cycle is dropped.
- Push only (jal=1, jr=0):
  - tos <= tos+1 (wraps DEPTH-1 -> 0); mem[tos+1] <= return address.
  - count <= min(count+1, DEPTH).
  - When full: overwrites the oldest entry; count stays DEPTH.
  - o_ras_valid <= 0.
- Pop only (jr=1, jal=0):
  - If count > 0: o_ras_target <= mem[tos], o_ras_valid <= 1, tos <= tos-1 (wraps 0 -> DEPTH-1), count <= count-1.
  - If count == 0 (underflow): o_ras_valid <= 0, o_ras_target <= 0, tos and count unchanged.
- Push and pop together (defensive; not produced by the pre-aligner):
  - Pop output is taken from the pre-edge top: valid = (count > 0), target = mem[tos] or 0.
  - mem[tos] <= return address; tos unchanged.
  - count <= (count == 0) ? 1 : count.
- Neither request: o_ras_valid <= 0; o_ras_target holds its value.
- Latency: prediction is registered; o_ras_valid rises the cycle after i_jr_inst is sampled.
- o_empty / o_full are combinational from the count register.
- Reset asserted mid-operation clears everything immediately; no request in flight survives.

Optional Feature:
- Macro: RAS_STATS_EN.
- With the macro defined, adds outputs:
  - o_push_count (16 bits): successful pushes.
  - o_overflow_count (16 bits): pushes while full.
  - o_underflow_count (16 bits): pops while empty.
  - All three are saturating at 16'hFFFF and reset to 0.
  - i_Stall freezes them; i_Flush does not clear them.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: after reset release -> o_empty = 1, o_full = 0, o_ras_valid = 0, o_ras_target = 0.
- Basic LIFO: push at addresses 22'h000100, 22'h000200, then jr x2 -> o_ras_target 22'h000201 then 22'h000101, each with o_ras_valid = 1 one cycle after its jr; then o_empty = 1.
- Overflow wrap: 9 pushes at addresses 1..9 (DEPTH = 8), then 9 pops -> targets 10, 9, ..., 3 valid; 9th pop has o_ras_valid = 0, target 0. With RAS_STATS_EN: overflow = 1, underflow = 1.
- Stall: push 22'h3FFFFF (return address wraps to 22'h000000), assert i_Stall and pulse jr -> no output change. Deassert stall, jr -> target 22'h000000, valid = 1.
- Flush: push 3 entries, i_Flush with a simultaneous jal -> count 0, o_empty = 1; the next jr gives valid = 0.
- Simultaneous: stack holding 22'h000051, present jal@22'h000080 and jr together -> target 22'h000051, valid = 1; the next jr gives 22'h000081.
